// File: rtl/eyeriss_pe_pkg.sv
// Shared definitions for the Eyeriss PE feeder blocks: feeder FSM state
// encoding, lane count of a packed filter word, and pixel-counter sizing.
package eyeriss_pe_pkg;

    typedef enum logic [1:0] {
        FEED_IDLE = 2'd0,
        FEED_FILL = 2'd1,
        FEED_PUSH = 2'd2,
        FEED_DONE = 2'd3
    } feeder_state_t;

    // Pixels per packed filter word (64-bit word / 16-bit pixel).
    localparam int LANES = 4;

    // Smallest counter width able to hold the largest S*p*q product.
    function automatic int calc_cnt_width(input int s_w, input int p_w, input int q_w);
        longint max_total;
        int     bits;
        max_total = ((longint'(1) << s_w) - 1) *
                    ((longint'(1) << p_w) - 1) *
                    ((longint'(1) << q_w) - 1);
        bits = 1;
        for (int b = 1; b < 62; b++) begin
            if ((longint'(1) << b) <= max_total) begin
                bits = b + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/filter_lane_packer.sv
// Filter lane packer: collects pixels into one packed word, lane 0 in the
// least significant slice. Unwritten lanes stay zero until the next clear.
module filter_lane_packer
    import eyeriss_pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = LANES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           pixel,
    output logic [DATA_WIDTH*NUM_LANES-1:0] word,
    output logic                            last_lane
);

    localparam int LANE_W = $clog2(NUM_LANES + 1);

    logic [LANE_W-1:0] lane;

    // Word register and lane index; clear wins over a write in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word <= '0;
            lane <= '0;
        end else if (clear) begin
            word <= '0;
            lane <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane == LANE_W'(i)) begin
                    word[i*DATA_WIDTH +: DATA_WIDTH] <= pixel;
                end
            end
            lane <= lane + 1'b1;
        end
    end

    // The next accepted pixel completes the word.
    always_comb begin
        last_lane = (lane == LANE_W'(NUM_LANES - 1));
    end

endmodule

// File: rtl/pe_filter_feeder.sv
// PE filter FIFO feeder: packs S*p*q upstream filter pixels into 64-bit
// words and pushes them into one PE's filter FIFO, stalling on full.
// Optional build macro FEEDER_STATS_EN adds a saturating stall_cycles count
// of PUSH cycles spent waiting on a full FIFO.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; S*p*q latched when start is accepted
// FILL  | accepting pixels into the word until 4 lanes or pass end
// PUSH  | presenting the word; holds while the FIFO reports full
// DONE  | one-cycle done pulse, then back to IDLE
module pe_filter_feeder
    import eyeriss_pe_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int DATA_WIDTH_FILTER = 64,
    parameter int S_WIDTH           = 5,
    parameter int p_WIDTH           = 5,
    parameter int q_WIDTH           = 3,
    parameter int CNT_WIDTH         = calc_cnt_width(S_WIDTH, p_WIDTH, q_WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [S_WIDTH-1:0]           S,
    input  logic [p_WIDTH-1:0]           p,
    input  logic [q_WIDTH-1:0]           q,
    output logic                         busy,
    output logic                         done,
    input  logic [DATA_WIDTH-1:0]        in_pixel,
    input  logic                         in_valid,
    output logic                         in_ready,
`ifdef FEEDER_STATS_EN
    output logic [15:0]                  stall_cycles,
`endif
    output logic [DATA_WIDTH_FILTER-1:0] filter,
    output logic                         push_filter,
    input  logic                         filter_fifo_full
);

    feeder_state_t          state;
    feeder_state_t          state_next;
    logic [CNT_WIDTH-1:0]   total;
    logic [CNT_WIDTH-1:0]   remaining;
    logic                   start_ok;
    logic                   accept;
    logic                   transfer;
    logic                   pack_clear;
    logic                   last_lane;

    // Pass size, handshake qualifiers and packer control.
    always_comb begin
        total      = CNT_WIDTH'(S) * CNT_WIDTH'(p) * CNT_WIDTH'(q);
        start_ok   = (state == FEED_IDLE) && start;
        accept     = (state == FEED_FILL) && in_valid;
        transfer   = (state == FEED_PUSH) && !filter_fifo_full;
        pack_clear = transfer || start_ok;
    end

    filter_lane_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (DATA_WIDTH_FILTER / DATA_WIDTH)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pack_clear),
        .wr_en     (accept),
        .pixel     (in_pixel),
        .word      (filter),
        .last_lane (last_lane)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FEED_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pixels still owed in this pass; loaded on start, one less per accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
        end else if (start_ok) begin
            remaining <= total;
        end else if (accept) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        in_ready    = 1'b0;
        push_filter = 1'b0;
        case (state)
            FEED_IDLE: begin
                if (start) begin
                    state_next = (total == '0) ? FEED_DONE : FEED_FILL;
                end
            end
            FEED_FILL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && (last_lane || remaining == CNT_WIDTH'(1))) begin
                    state_next = FEED_PUSH;
                end
            end
            FEED_PUSH: begin
                busy        = 1'b1;
                push_filter = !filter_fifo_full;
                if (!filter_fifo_full) begin
                    state_next = (remaining == '0) ? FEED_DONE : FEED_FILL;
                end
            end
            FEED_DONE: begin
                done       = 1'b1;
                state_next = FEED_IDLE;
            end
            default: begin
                state_next = FEED_IDLE;
            end
        endcase
    end

`ifdef FEEDER_STATS_EN
    // Saturating count of PUSH cycles blocked by a full FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if ((state == FEED_PUSH) && filter_fifo_full && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_filter_feeder.sv
// Directed bench for pe_filter_feeder. Inputs change just after the falling
// edge and outputs are checked 1 ns later, well away from the rising edge.
module tb_pe_filter_feeder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  S;
    logic [4:0]  p;
    logic [2:0]  q;
    logic        busy;
    logic        done;
    logic [15:0] in_pixel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] filter;
    logic        push_filter;
    logic        filter_fifo_full;
`ifdef FEEDER_STATS_EN
    logic [15:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    pe_filter_feeder dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .S                (S),
        .p                (p),
        .q                (q),
        .busy             (busy),
        .done             (done),
        .in_pixel         (in_pixel),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
`ifdef FEEDER_STATS_EN
        .stall_cycles     (stall_cycles),
`endif
        .filter           (filter),
        .push_filter      (push_filter),
        .filter_fifo_full (filter_fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // One FILL beat carrying a valid pixel.
    task automatic feed(input logic [15:0] px);
        step();
        in_valid = 1'b1;
        in_pixel = px;
        #1;
        check("fill_in_ready", in_ready, 1);
        check("fill_no_push", push_filter, 0);
    endtask

    initial begin
        reset            = 1'b0;
        start            = 1'b0;
        S                = '0;
        p                = '0;
        q                = '0;
        in_pixel         = '0;
        in_valid         = 1'b0;
        filter_fifo_full = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_push", push_filter, 0);
        check("rst_filter", filter, 0);
        step();
        step();
        reset = 1'b1;

        // 1: S=3,p=1,q=1 -> one partial word 0x0000_0003_0002_0001
        step();
        start = 1'b1; S = 5'd3; p = 5'd1; q = 3'd1;
        #1;
        check("t1_idle_busy", busy, 0);
        step();
        start = 1'b0;
        S = 5'd9;  // must not affect the running pass
        #1;
        check("t1_busy", busy, 1);
        feed(16'h0001);
        feed(16'h0002);
        feed(16'h0003);
        step();
        in_valid = 1'b0;
        #1;
        check("t1_push", push_filter, 1);
        check("t1_word", filter, 64'h0000_0003_0002_0001);
        check("t1_push_ready", in_ready, 0);
        step();
        #1;
        check("t1_done", done, 1);
        check("t1_done_push", push_filter, 0);
        check("t1_done_busy", busy, 0);

        // 2: back-to-back start, S=2,p=2,q=2 -> two full words; start while busy ignored
        step();
        start = 1'b1; S = 5'd2; p = 5'd2; q = 3'd2;
        #1;
        check("t2_done_cleared", done, 0);
        step();
        S = 5'd1; p = 5'd1; q = 3'd1;  // start held high during FILL
        feed(16'h0010);
        feed(16'h0011);
        start = 1'b0;
        feed(16'h0012);
        feed(16'h0013);
        step();
        in_valid = 1'b0;
        #1;
        check("t2_push1", push_filter, 1);
        check("t2_word1", filter, 64'h0013_0012_0011_0010);
        feed(16'h0014);
        feed(16'h0015);
        feed(16'h0016);
        feed(16'h0017);
        step();
        in_valid = 1'b0;
        #1;
        check("t2_push2", push_filter, 1);
        check("t2_word2", filter, 64'h0017_0016_0015_0014);
        step();
        #1;
        check("t2_done", done, 1);
        step();
        #1;
        check("t2_idle_busy", busy, 0);
        check("t2_idle_push", push_filter, 0);

        // 3: FIFO full for 5 PUSH cycles, then exactly one push
        start = 1'b1; S = 5'd4; p = 5'd1; q = 3'd1;
        filter_fifo_full = 1'b1;
        step();
        start = 1'b0;
        feed(16'h000A);
        feed(16'h000B);
        feed(16'h000C);
        feed(16'h000D);
        for (int i = 0; i < 5; i++) begin
            step();
            in_valid = 1'b0;
            #1;
            check("t3_stall_push", push_filter, 0);
            check("t3_stall_word", filter, 64'h000D_000C_000B_000A);
            check("t3_stall_busy", busy, 1);
        end
        step();
        filter_fifo_full = 1'b0;
        #1;
        check("t3_release_push", push_filter, 1);
        check("t3_release_word", filter, 64'h000D_000C_000B_000A);
`ifdef FEEDER_STATS_EN
        check("t3_stall_cycles", stall_cycles, 5);
`endif
        step();
        #1;
        check("t3_done", done, 1);
        check("t3_single_push", push_filter, 0);

        // 4: in_valid toggling in FILL, S=5 -> full word plus partial word
        step();
        start = 1'b1; S = 5'd5; p = 5'd1; q = 3'd1;
        step();
        start = 1'b0;
        feed(16'h0021);
        step(); in_valid = 1'b0; in_pixel = 16'hFFFF;
        feed(16'h0022);
        step(); in_valid = 1'b0; in_pixel = 16'hEEEE;
        #1;
        check("t4_gap_no_push", push_filter, 0);
        feed(16'h0023);
        step(); in_valid = 1'b0; in_pixel = 16'hDDDD;
        feed(16'h0024);
        step();
        in_valid = 1'b0;
        #1;
        check("t4_push1", push_filter, 1);
        check("t4_word1", filter, 64'h0024_0023_0022_0021);
        step(); in_valid = 1'b0; in_pixel = 16'hCCCC;
        #1;
        check("t4_gap_ready", in_ready, 1);
        feed(16'h0025);
        step();
        in_valid = 1'b0;
        #1;
        check("t4_push2", push_filter, 1);
        check("t4_word2_partial", filter, 64'h0000_0000_0000_0025);
        step();
        #1;
        check("t4_done", done, 1);

        // 5: S=0 -> no push, done pulse right after the start cycle
        step();
        start = 1'b1; S = 5'd0; p = 5'd3; q = 3'd2;
        #1;
        check("t5_start_busy", busy, 0);
        step();
        start = 1'b0;
        #1;
        check("t5_done", done, 1);
        check("t5_no_push", push_filter, 0);
        check("t5_busy", busy, 0);
        step();
        #1;
        check("t5_done_once", done, 0);

        // 6: reset mid-pass after 2 pixels, then a clean one-pixel pass
        start = 1'b1; S = 5'd4; p = 5'd1; q = 3'd1;
        step();
        start = 1'b0;
        feed(16'h0031);
        feed(16'h0032);
        step();
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_push", push_filter, 0);
        check("t6_rst_filter", filter, 0);
        check("t6_rst_done", done, 0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("t6_post_push", push_filter, 0);
            check("t6_post_busy", busy, 0);
        end
        start = 1'b1; S = 5'd1; p = 5'd1; q = 3'd1;
        step();
        start = 1'b0;
        feed(16'h0055);
        step();
        in_valid = 1'b0;
        #1;
        check("t6_clean_push", push_filter, 1);
        check("t6_clean_word", filter, 64'h0000_0000_0000_0055);
        step();
        #1;
        check("t6_clean_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
